// File: rtl/midi_in_arbiter.sv
// Message-aware arbiter merging two MIDI byte streams (UART receiver "u" and
// control processor "c") into one paced stream for the MIDI decoder. Each
// source is buffered in its own FIFO. Sources are switched only at message
// boundaries, or when the granted source stalls for too long.
`timescale 1ns/1ps
module midi_in_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       byteready_u,
  input  logic [7:0] cur_status_u,
  input  logic [7:0] midibyte_nr_u,
  input  logic [7:0] midi_in_data_u,
  input  logic       byteready_c,
  input  logic [7:0] cur_status_c,
  input  logic [7:0] midibyte_nr_c,
  input  logic [7:0] midi_in_data_c,
  input  logic       ovf_clr,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_in_data,
  output logic [1:0] grant,
  output logic       ovf_u,
  output logic       ovf_c,
  output logic       timeout
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // State encoding doubles as the one-hot grant output ([1]=u, [0]=c).
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrantU = 2'b10,
    StGrantC = 2'b01
  } state_e;

  // Source index 1 is u, index 0 is c, matching the grant bit positions.
  logic [1:0]      strobe;
  logic [23:0]     din      [2];
  logic [23:0]     mem_q    [2][FIFO_DEPTH];
  logic [23:0]     head     [2];
  logic [PtrW-1:0] wptr_q   [2];
  logic [PtrW-1:0] wptr_d   [2];
  logic [PtrW-1:0] rptr_q   [2];
  logic [PtrW-1:0] rptr_d   [2];
  logic [CntW-1:0] cnt_q    [2];
  logic [CntW-1:0] cnt_d    [2];
  logic [1:0]      full;
  logic [1:0]      nempty;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      ovf_q;
  logic [1:0]      ovf_d;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            src;
  logic            active;

  logic            byteready_q, byteready_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      nr_q, nr_d;
  logic [7:0]      data_q, data_d;
  logic            timeout_q, timeout_d;

  // Decide whether the popped entry closes its MIDI message.
  function automatic logic msg_end(input logic [23:0] e);
    logic [7:0] s;
    logic [7:0] n;
    logic [7:0] d;
    logic       r;
    s = e[23:16];
    n = e[15:8];
    d = e[7:0];
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: r = (n >= 8'd2);
      4'hC, 4'hD:                   r = (n >= 8'd1);
      4'hF:                         r = (s == 8'hF0) ? (d == 8'hF7) : 1'b1;
      default:                      r = 1'b1;  // s < 80: treat every byte as a message
    endcase
    return r;
  endfunction

  // Pack source inputs into per-source strobe and entry vectors.
  always_comb begin
    strobe = {byteready_u, byteready_c};
    din[1] = {cur_status_u, midibyte_nr_u, midi_in_data_u};
    din[0] = {cur_status_c, midibyte_nr_c, midi_in_data_c};
  end

  // FIFO status; full is taken from the registered count, so a push into a
  // full FIFO is dropped even if that FIFO pops in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]   = (cnt_q[i] == CntW'(FIFO_DEPTH));
      nempty[i] = (cnt_q[i] != '0);
      push[i]   = strobe[i] && !full[i];
      head[i]   = mem_q[i][rptr_q[i]];
    end
  end

  // Arbitration, pop, pacing and timeout next-state logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gap_d       = (gap_q != '0) ? gap_q - GapW'(1) : gap_q;
    tmo_d       = tmo_q;
    pop         = '0;
    src         = 1'b0;
    active      = 1'b0;
    byteready_d = 1'b0;
    status_d    = status_q;
    nr_d        = nr_q;
    data_d      = data_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d  = '0;
        active = |nempty;
        // On a tie prefer the source that was not served last.
        src    = (nempty == 2'b11) ? ~last_q : nempty[1];
      end
      StGrantU: begin
        active = 1'b1;
        src    = 1'b1;
      end
      StGrantC: begin
        active = 1'b1;
        src    = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (active) begin
      if (nempty[src] && (gap_q == '0)) begin
        pop[src]    = 1'b1;
        byteready_d = 1'b1;
        status_d    = head[src][23:16];
        nr_d        = head[src][15:8];
        data_d      = head[src][7:0];
        gap_d       = GapW'(GAP_CYCLES);
        tmo_d       = '0;
        if (msg_end(head[src])) begin
          state_d = StIdle;
          last_d  = src;
        end else begin
          state_d = src ? StGrantU : StGrantC;
        end
      end else if (state_q == StIdle) begin
        // Pacing gap still running: take the grant now, pop later.
        state_d = src ? StGrantU : StGrantC;
      end else if (!nempty[src]) begin
        if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          last_d    = src;
          tmo_d     = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
    end
  end

  // FIFO pointer/count next state and sticky overflow flags.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = push[i] ? wptr_q[i] + PtrW'(1) : wptr_q[i];
      rptr_d[i] = pop[i] ? rptr_q[i] + PtrW'(1) : rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
      // A drop in the same cycle as a clear wins.
      ovf_d[i] = ovf_clr ? 1'b0 : ovf_q[i];
      if (strobe[i] && full[i]) begin
        ovf_d[i] = 1'b1;
      end
    end
  end

  // FIFO storage; needs no reset since the pointers define occupancy.
  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= din[i];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= 1'b0;
      gap_q       <= '0;
      tmo_q       <= '0;
      byteready_q <= 1'b0;
      status_q    <= '0;
      nr_q        <= '0;
      data_q      <= '0;
      timeout_q   <= 1'b0;
      ovf_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      byteready_q <= byteready_d;
      status_q    <= status_d;
      nr_q        <= nr_d;
      data_q      <= data_d;
      timeout_q   <= timeout_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign byteready    = byteready_q;
  assign cur_status   = status_q;
  assign midibyte_nr  = nr_q;
  assign midi_in_data = data_q;
  assign grant        = state_q;
  assign ovf_u        = ovf_q[1];
  assign ovf_c        = ovf_q[0];
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_midi_in_arbiter.sv
// Scoreboard bench for midi_in_arbiter: stimulus pushes the expected output
// entries, a negedge monitor pops and compares on every byteready strobe.
`timescale 1ns/1ps
module tb_midi_in_arbiter;

  localparam int unsigned Depth = 4;
  localparam int unsigned Gap   = 2;
  localparam int unsigned Tmo   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       br_u = 1'b0, br_c = 1'b0;
  logic [7:0] st_u = '0, nr_u = '0, d_u = '0;
  logic [7:0] st_c = '0, nr_c = '0, d_c = '0;
  logic       ovf_clr = 1'b0;
  logic       byteready;
  logic [7:0] cur_status, midibyte_nr, midi_in_data;
  logic [1:0] grant;
  logic       ovf_u, ovf_c, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [23:0] exp_q [$];

  midi_in_arbiter #(
    .FIFO_DEPTH(Depth),
    .GAP_CYCLES(Gap),
    .TIMEOUT   (Tmo)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .byteready_u   (br_u),
    .cur_status_u  (st_u),
    .midibyte_nr_u (nr_u),
    .midi_in_data_u(d_u),
    .byteready_c   (br_c),
    .cur_status_c  (st_c),
    .midibyte_nr_c (nr_c),
    .midi_in_data_c(d_c),
    .ovf_clr       (ovf_clr),
    .byteready     (byteready),
    .cur_status    (cur_status),
    .midibyte_nr   (midibyte_nr),
    .midi_in_data  (midi_in_data),
    .grant         (grant),
    .ovf_u         (ovf_u),
    .ovf_c         (ovf_c),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output strobe must match the next expected entry and
  // respect the minimum spacing of Gap+1 cycles.
  int  last_br_cyc = 0;
  bit  have_last = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      have_last = 1'b0;
    end else if (byteready) begin
      logic [23:0] got;
      logic [23:0] exp;
      got = {cur_status, midibyte_nr, midi_in_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h, required no output", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL out_data: got %h, required %h (cycle %0d)", got, exp, cyc);
        end
      end
      if (have_last) begin
        checks++;
        if (cyc - last_br_cyc < int'(Gap) + 1) begin
          errors++;
          $display("FAIL out_spacing: got %0d cycles, required >= %0d",
                   cyc - last_br_cyc, Gap + 1);
        end
      end
      last_br_cyc = cyc;
      have_last   = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] s, input logic [7:0] n, input logic [7:0] d);
    exp_q.push_back({s, n, d});
  endtask

  // One-cycle strobe on u (is_u=1) or c (is_u=0).
  task automatic send(input bit is_u, input logic [7:0] s, input logic [7:0] n,
                      input logic [7:0] d);
    if (is_u) begin
      br_u = 1'b1; st_u = s; nr_u = n; d_u = d;
    end else begin
      br_c = 1'b1; st_c = s; nr_c = n; d_c = d;
    end
    tick(1);
    br_u = 1'b0;
    br_c = 1'b0;
  endtask

  task automatic send_both(input logic [7:0] su, input logic [7:0] nu, input logic [7:0] du,
                           input logic [7:0] sc, input logic [7:0] nc, input logic [7:0] dc);
    br_u = 1'b1; st_u = su; nr_u = nu; d_u = du;
    br_c = 1'b1; st_c = sc; nr_c = nc; d_c = dc;
    tick(1);
    br_u = 1'b0;
    br_c = 1'b0;
  endtask

  // Wait (bounded) until every expected entry has been output and grant is idle.
  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || grant != 2'b00) && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: got %0d entries pending, grant %b, required 0 and 00",
               name, exp_q.size(), grant);
    end
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int in_cyc;
    int br_cyc;
    int to_cyc;
    int n;

    // Reset state.
    tick(2);
    reset = 1'b0;
    chk("rst_byteready", {31'd0, byteready}, 32'd0);
    chk("rst_outputs", {8'd0, cur_status, midibyte_nr, midi_in_data}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_flags", {29'd0, ovf_u, ovf_c, timeout}, 32'd0);

    // Single source Note On: first strobe 2 cycles after input.
    expect_out(8'h90, 8'h01, 8'h3C);
    expect_out(8'h90, 8'h02, 8'h64);
    in_cyc = cyc;
    send(1'b1, 8'h90, 8'h01, 8'h3C);
    send(1'b1, 8'h90, 8'h02, 8'h64);
    chk("lat_byteready", {31'd0, byteready}, 32'd1);
    chk("lat_cycles", cyc - in_cyc, 32'd2);
    chk("lat_data", {24'd0, midi_in_data}, 32'h3C);
    chk("single_grant_u", {30'd0, grant}, 32'b10);
    drain("single");
    chk("single_grant_idle", {30'd0, grant}, 32'd0);

    // Ties after reset: u wins first, then alternation.
    do_reset();
    expect_out(8'hC0, 8'h01, 8'h05);
    expect_out(8'hC0, 8'h01, 8'h07);
    expect_out(8'hC0, 8'h01, 8'h15);
    expect_out(8'hC0, 8'h01, 8'h17);
    send_both(8'hC0, 8'h01, 8'h05, 8'hC0, 8'h01, 8'h07);
    send_both(8'hC0, 8'h01, 8'h15, 8'hC0, 8'h01, 8'h17);
    tick(1);
    chk("tie2_grant_c", {30'd0, grant}, 32'b01);
    drain("tie");

    // u message in progress must not be interleaved with c's CC.
    expect_out(8'h90, 8'h01, 8'h3C);
    expect_out(8'h90, 8'h02, 8'h40);
    expect_out(8'hB0, 8'h01, 8'h07);
    expect_out(8'hB0, 8'h02, 8'h7F);
    send(1'b1, 8'h90, 8'h01, 8'h3C);
    send(1'b0, 8'hB0, 8'h01, 8'h07);
    send(1'b0, 8'hB0, 8'h02, 8'h7F);
    tick(8);
    chk("nointl_grant_u", {30'd0, grant}, 32'b10);
    send(1'b1, 8'h90, 8'h02, 8'h40);
    drain("nointl");

    // Overflow: c granted and stalled, five strobes into u.
    expect_out(8'h90, 8'h01, 8'h11);
    expect_out(8'h90, 8'h02, 8'h22);
    for (int i = 1; i <= 4; i++) expect_out(8'hC0, 8'h01, 8'(i));
    send(1'b0, 8'h90, 8'h01, 8'h11);
    for (int i = 1; i <= 5; i++) send(1'b1, 8'hC0, 8'h01, 8'(i));
    chk("ovf_u_set", {31'd0, ovf_u}, 32'd1);
    chk("ovf_c_clear", {31'd0, ovf_c}, 32'd0);
    chk("ovf_grant_c", {30'd0, grant}, 32'b01);
    send(1'b0, 8'h90, 8'h02, 8'h22);
    drain("ovf");
    chk("ovf_u_sticky", {31'd0, ovf_u}, 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_u_cleared", {31'd0, ovf_u}, 32'd0);

    // Timeout: u stalls mid Note On, c waits behind it.
    expect_out(8'h90, 8'h01, 8'h3C);
    expect_out(8'hC0, 8'h01, 8'h55);
    send(1'b1, 8'h90, 8'h01, 8'h3C);
    send(1'b0, 8'hC0, 8'h01, 8'h55);
    chk("tmo_first_out", {31'd0, byteready}, 32'd1);
    br_cyc = cyc;
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    to_cyc = cyc;
    chk("tmo_seen", {31'd0, timeout}, 32'd1);
    chk("tmo_delay", to_cyc - br_cyc, Tmo);
    chk("tmo_grant_idle", {30'd0, grant}, 32'd0);
    tick(1);
    chk("tmo_pulse_one", {31'd0, timeout}, 32'd0);
    drain("tmo");

    // Sysex holds the grant until F7 is popped.
    expect_out(8'hF0, 8'h01, 8'h01);
    expect_out(8'hF0, 8'h02, 8'h02);
    expect_out(8'hF0, 8'h03, 8'hF7);
    expect_out(8'hC0, 8'h01, 8'h66);
    send(1'b1, 8'hF0, 8'h01, 8'h01);
    send_both(8'hF0, 8'h02, 8'h02, 8'hC0, 8'h01, 8'h66);
    send(1'b1, 8'hF0, 8'h03, 8'hF7);
    tick(3);
    chk("sysex_grant_u", {30'd0, grant}, 32'b10);
    drain("sysex");

    // Reset mid-sysex discards the buffered tail.
    expect_out(8'hF0, 8'h01, 8'h0A);
    send(1'b1, 8'hF0, 8'h01, 8'h0A);
    send(1'b1, 8'hF0, 8'h02, 8'h0B);
    send(1'b1, 8'hF0, 8'h03, 8'h0C);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst_outputs", {7'd0, byteready, cur_status, midibyte_nr, midi_in_data}, 32'd0);
    chk("mrst_grant", {30'd0, grant}, 32'd0);
    tick(10);
    expect_out(8'hC0, 8'h01, 8'h77);
    send(1'b0, 8'hC0, 8'h01, 8'h77);
    drain("mrst");
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
